// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter (and a future receiver).
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  // Device falling-edge numbering within one host-to-device frame.
  localparam int unsigned PARITY_EDGE = 9;
  localparam int unsigned STOP_EDGE   = 10;
  localparam int unsigned FINAL_EDGE  = 11;

  // Default timing at the reference system clock.
  localparam int unsigned DEF_CLK_HZ         = 100_000_000;
  localparam int unsigned DEF_INHIBIT_CYCLES = 10_000;      // 100 us
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2_000_000;   // 20 ms

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       start;
  logic [7:0] tx_byte;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (output start, tx_byte, input busy, done, ack_err, timeout_err);
  modport slave  (input start, tx_byte, output busy, done, ack_err, timeout_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a falling-edge
// detector on the synced clock. Idle level of both lines is high, so the flops
// reset to 1 to avoid a phantom edge when reset is released.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2clk_i,
  input  logic ps2data_i,
  output logic clk_lvl_o,
  output logic data_lvl_o,
  output logic clk_fall_o
);

  logic [1:0] clk_sync_q,  clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q,  clk_prev_d;

  // Shift the raw lines into the synchronizer chains.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2clk_i};
    data_sync_d = {data_sync_q[0], ps2data_i};
    clk_prev_d  = clk_sync_q[1];
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_lvl_o  = clk_sync_q[1];
  assign data_lvl_o = data_sync_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line control.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | lines released, waiting for start
// ST_INHIBIT   | host holds clock low; data pulled low in the final cycle
// ST_REQ       | clock released, data low (start bit); timeout armed
// ST_BITS      | device edges 1-10 shift out data, parity, then stop
// ST_ACK       | waiting for edge 11 to sample the device acknowledge
// ST_WAIT_IDLE | waiting for both lines high before reporting the outcome
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned INHIBIT_CYCLES = CLK_HZ / (DEF_CLK_HZ / DEF_INHIBIT_CYCLES),
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / (DEF_CLK_HZ / DEF_TIMEOUT_CYCLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2clk_i,
  input  logic         ps2data_i,
  output logic         ps2clk_oe,
  output logic         ps2data_oe,
  output wire          ps2clk_pad,
  output wire          ps2data_pad
);

  // One down-counter serves both the inhibit hold and the transfer timeout,
  // since the two phases never overlap.
  localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);

  logic clk_lvl, data_lvl, clk_fall;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2clk_i   (ps2clk_i),
    .ps2data_i  (ps2data_i),
    .clk_lvl_o  (clk_lvl),
    .data_lvl_o (data_lvl),
    .clk_fall_o (clk_fall)
  );

  ps2_tx_state_e    state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       edge_q, edge_d;
  logic [7:0]       byte_q, byte_d;
  logic             parity_q, parity_d;
  logic             ack_bad_q, ack_bad_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic [3:0]       edge_nxt;

  assign edge_nxt = edge_q + 4'd1;

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    edge_d        = edge_q;
    byte_d        = byte_q;
    parity_d      = parity_q;
    ack_bad_d     = ack_bad_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (bus.start) begin
          byte_d    = bus.tx_byte;
          parity_d  = odd_parity(bus.tx_byte);
          tmr_d     = INHIBIT_LOAD;
          edge_d    = '0;
          ack_bad_d = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
          busy_d    = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (tmr_q == '0) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
          if (tmr_q == TMR_ONE) data_oe_d = 1'b1;
        end
      end

      ST_REQ: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        tmr_d     = TIMEOUT_LOAD;
        edge_d    = '0;
        state_d   = ST_BITS;
      end

      ST_BITS, ST_ACK: begin
        if (tmr_q <= TMR_ONE) begin
          // Device stalled: abandon the frame and free the bus.
          clk_oe_d      = 1'b0;
          data_oe_d     = 1'b0;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          tmr_d         = '0;
          edge_d        = '0;
          state_d       = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
          if (clk_fall) begin
            if (state_q == ST_BITS) begin
              edge_d = edge_nxt;
              if (edge_nxt <= 4'd8) begin
                data_oe_d = ~byte_q[edge_q[2:0]];
              end else if (edge_nxt == 4'(PARITY_EDGE)) begin
                data_oe_d = ~parity_q;
              end else begin
                data_oe_d = 1'b0;
                if (edge_nxt == 4'(STOP_EDGE)) state_d = ST_ACK;
              end
            end else begin
              edge_d    = 4'(FINAL_EDGE);
              ack_bad_d = data_lvl;
              state_d   = ST_WAIT_IDLE;
            end
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          done_d    = ~ack_bad_q;
          ack_err_d = ack_bad_q;
          busy_d    = 1'b0;
          tmr_d     = '0;
          edge_d    = '0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases both lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      edge_q        <= '0;
      byte_q        <= '0;
      parity_q      <= 1'b0;
      ack_bad_q     <= 1'b0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      edge_q        <= edge_d;
      byte_q        <= byte_d;
      parity_q      <= parity_d;
      ack_bad_q     <= ack_bad_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ps2clk_oe       = clk_oe_q;
  assign ps2data_oe      = data_oe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.timeout_err = timeout_err_q;

  // Open-drain pads: pull low when enabled, otherwise float to the pull-up.
  assign ps2clk_pad  = ps2clk_oe  ? 1'b0 : 1'bz;
  assign ps2data_pad = ps2data_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 1500;
  localparam int HP = 25;

  localparam int K_DONE = 0, K_ACKERR = 1, K_TIMEOUT = 2;
  localparam int M_ACK = 0, M_NOACK = 1, M_SILENT = 2, M_RESET = 3;

  typedef struct {
    logic [7:0] b;
    int         kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2clk_oe, ps2data_oe;
  logic ps2clk_line, ps2data_line;
  wire  ps2clk_pad, ps2data_pad;

  int     checks = 0;
  int     errors = 0;
  int     pulses_seen = 0;
  longint cyc = 0;
  longint req_cyc = 0;
  exp_t       exp_q[$];
  logic [9:0] rx_q[$];

  ps2_host_tx_if bus ();

  assign ps2clk_line  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_line = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ         (100_000_000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .ps2clk_i    (ps2clk_line),
    .ps2data_i   (ps2data_line),
    .ps2clk_oe   (ps2clk_oe),
    .ps2data_oe  (ps2data_oe),
    .ps2clk_pad  (ps2clk_pad),
    .ps2data_pad (ps2data_pad)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as the device should see it: 8 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  // PS/2 keyboard-side model: observes the request, clocks the frame, acks.
  task automatic device(input int mode);
    int n_clk, n_both, guard;
    logic [9:0] frame;
    check("inhibit_clk_oe_start", ps2clk_oe, 1);
    check("clk_pad_low", ps2clk_pad, 0);
    n_clk = 0; n_both = 0; guard = 0;
    while (ps2clk_oe && guard < int'(INH) + 50) begin
      n_clk++;
      if (ps2data_oe) n_both++;
      guard++;
      @(negedge clk);
    end
    check("inhibit_len", n_clk, INH);
    check("inhibit_data_last_only", n_both, 1);
    req_cyc = cyc;
    check("req_start_bit", ps2data_line, 0);
    check("data_pad_low", ps2data_pad, 0);
    if (mode == M_SILENT) return;
    repeat (HP) @(negedge clk);
    frame = '0;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (mode == M_RESET && k == 5) begin
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_clk_oe", ps2clk_oe, 0);
        check("reset_data_oe", ps2data_oe, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_pulses", bus.done | bus.ack_err | bus.timeout_err, 0);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      repeat (HP) @(negedge clk);
      if (k <= 10) frame[k-1] = ps2data_line;
      if (k == 10) rx_q.push_back(frame);
      dev_clk_low = 1'b0;
      if (k == 10 && mode == M_ACK) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
      repeat (HP) @(negedge clk);
    end
  endtask

  // Monitor: whenever an outcome pulse appears, pop and compare.
  always @(negedge clk) begin
    int n, k;
    exp_t e;
    logic [9:0] f;
    if (rst_n && (bus.done || bus.ack_err || bus.timeout_err)) begin
      n = int'(bus.done) + int'(bus.ack_err) + int'(bus.timeout_err);
      check("pulse_onehot", n, 1);
      pulses_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: done=%0d ack_err=%0d timeout_err=%0d with nothing pending",
                 bus.done, bus.ack_err, bus.timeout_err);
      end else begin
        e = exp_q.pop_front();
        k = bus.done ? K_DONE : (bus.ack_err ? K_ACKERR : K_TIMEOUT);
        check("outcome_kind", k, e.kind);
        check("busy_low_at_pulse", bus.busy, 0);
        if (e.kind == K_TIMEOUT) begin
          check("timeout_latency", cyc - req_cyc, TMO);
          check("timeout_release", {ps2clk_oe, ps2data_oe}, 0);
        end else if (rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_missing: device captured no frame for byte %02h", e.b);
        end else begin
          f = rx_q.pop_front();
          check("frame_bits", f, ref_frame(e.b));
        end
      end
    end
  end

  task automatic run(input logic [7:0] b, input int mode, input bit disturb);
    int base, guard;
    exp_t e;
    guard = 0;
    while (bus.busy && guard < 5000) begin guard++; @(negedge clk); end
    base = pulses_seen;
    bus.start = 1'b1;
    bus.tx_byte = b;
    if (mode != M_RESET) begin
      e.b = b;
      e.kind = (mode == M_ACK) ? K_DONE : (mode == M_NOACK) ? K_ACKERR : K_TIMEOUT;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.tx_byte = 8'($urandom);
    check("busy_after_start", bus.busy, 1);
    fork
      device(mode);
      if (disturb) begin
        repeat (150) @(negedge clk);
        bus.start = 1'b1;
        bus.tx_byte = ~b;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    if (mode == M_RESET) begin
      repeat (20) @(negedge clk);
      check("no_pulse_after_reset", pulses_seen, base);
    end else begin
      guard = 0;
      while (pulses_seen == base && guard < int'(TMO) + 200) begin guard++; @(negedge clk); end
      if (pulses_seen == base) begin
        checks++; errors++;
        $display("FAIL outcome_wait: no completion pulse within %0d cycles", TMO + 200);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.tx_byte = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2clk_oe, 0);
    check("rst_data_oe", ps2data_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ack_err", bus.ack_err, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run(8'hED, M_ACK, 1'b0);
    run(8'h01, M_ACK, 1'b0);
    run(8'hFF, M_ACK, 1'b0);
    run(8'h5A, M_NOACK, 1'b0);
    run(8'h3C, M_SILENT, 1'b0);
    run(8'hA7, M_RESET, 1'b0);
    run(8'($urandom), M_ACK, 1'b0);
    run(8'h96, M_ACK, 1'b1);
    for (int i = 0; i < 8; i++)
      run(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK, 1'b0);

    repeat (20) @(negedge clk);
    check("expected_queue_drained", exp_q.size(), 0);
    check("frame_queue_drained", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter INHIBIT_CYCLES, default 10000, number of cycles the host holds ps2clk low (100 us at 100 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 2000000, maximum cycles from clock release to the 11th device falling edge (20 ms).
REQ-004 CLK  input  1  system clock; the block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to send tx_byte; accepted only when busy=0.
REQ-007 tx_byte  input  8  command byte, e.g. 0xED for set-LEDs; sampled on the accepting cycle.
REQ-008 ps2clk_i  input  1  raw PS/2 clock line level (asynchronous).
REQ-009 ps2data_i  input  1  raw PS/2 data line level (asynchronous).
REQ-010 ps2clk_oe  output  1  1 = drive PS/2 clock low; 0 = release (open-drain).
REQ-011 ps2data_oe  output  1  1 = drive PS/2 data low; 0 = release.
REQ-012 busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-013 done  output  1  one-cycle pulse: transfer completed and device acknowledged.
REQ-014 ack_err  output  1  one-cycle pulse: device did not drive data low at the ACK edge.
REQ-015 timeout_err  output  1  one-cycle pulse: transfer aborted by the timeout.

Function
REQ-016 ps2clk_i and ps2data_i SHALL pass through 2-flop synchronizers; a falling edge is synced clock 1 -> 0, giving 3 cycles of detection latency.
REQ-017 State machine SHALL have the states IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE.
REQ-018 IDLE: both oe=0; start=1 latches tx_byte, computes odd parity (~^tx_byte), and goes to INHIBIT on the next cycle.
REQ-019 INHIBIT: ps2clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2data_oe=1 is asserted in the last cycle; then the block goes to REQ.
REQ-020 REQ: ps2data_oe=1 (start bit) and ps2clk_oe=0; the timeout counter is cleared; the block goes to BITS.
REQ-021 BITS: a 4-bit edge counter counts device falling edges; edges 1-8 drive ps2data_oe = ~tx_byte[edge-1] (LSB first), edge 9 drives ~parity, and edge 10 releases data (stop bit).
REQ-022 ps2data_oe SHALL change in the cycle after the detected falling edge and SHALL hold until the next edge.
REQ-023 ACK: on the 11th falling edge, synced data is sampled; 0 = acknowledge, 1 = ack_err condition; both cases go to WAIT_IDLE.
REQ-024 WAIT_IDLE: the block waits until synced clock and data are both 1, then pulses done (or ack_err), drops busy in the same cycle, and returns to IDLE.
REQ-025 Timeout: in REQ, BITS or ACK, if the counter reaches TIMEOUT_CYCLES the block releases both lines, pulses timeout_err, and goes to IDLE.
REQ-026 done, ack_err and timeout_err SHALL be mutually exclusive, and exactly one pulses per accepted transfer.
REQ-027 start while busy=1 SHALL be ignored and is not queued.
REQ-028 Falling edges seen in IDLE or INHIBIT SHALL be ignored.

Reset
REQ-029 RST_N=0 SHALL immediately force: state IDLE, ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, ack_err=0, timeout_err=0, counters=0.
REQ-030 Reset mid-transfer SHALL release both lines with no pulse outputs.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum, the final edge count (11), and the default timing constants.
REQ-032 Sub-module ps2_sync_edge SHALL contain the 2-flop synchronizers and the falling-edge detector, and is shareable with the receiver.
REQ-033 The top level SHALL provide the tri-state pads: line = oe ? 0 : z.

Verification
REQ-034 tx_byte=0xED with a device model that acks: data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, done pulses once, busy falls.
REQ-035 tx_byte=0x01: parity bit 0; tx_byte=0xFF: parity bit 1; the device model checks the received frame.
REQ-036 Device drives no ack (data high at edge 11) -> ack_err=1 for one cycle, done=0.
REQ-037 Device never clocks after REQ -> timeout_err exactly TIMEOUT_CYCLES cycles after REQ, and both oe=0.
REQ-038 RST_N low at edge 5 -> both oe=0 in the same cycle and no pulses; a later start runs a clean transfer.
REQ-039 start pulsed during BITS -> ignored, and the in-flight byte completes unchanged.
